// File: rtl/vector_alu_pkg.sv
// Shared definitions for the pipelined vector ALU: opcodes, FSM states,
// lane indexing and the saturation helper used when VALU_SAT_EN is defined.
package vector_alu_pkg;

  localparam logic [3:0] OP_VADD = 4'd0;
  localparam logic [3:0] OP_VDOT = 4'd1;
  localparam logic [3:0] OP_SMUL = 4'd2;
  localparam logic [3:0] OP_SST  = 4'd3;
  localparam logic [3:0] OP_VLD  = 4'd4;
  localparam logic [3:0] OP_VST  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SLH  = 4'd7;
  localparam logic [3:0] OP_NOP  = 4'd15;

  // Intermediate width for narrowing; wide enough for any lane sum/product
  // and for the VDOT accumulator at the default sizes.
  localparam int SAT_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DOT  = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Bit offset of lane 'lane' in a packed vector of 'lane_w'-bit lanes.
  function automatic int lane_lsb(input int lane, input int lane_w);
    return lane * lane_w;
  endfunction

  // Clamp a signed value to the signed range of a 'w'-bit integer.
  function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] v,
                                                       input int w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = $signed((64'd1 << (w - 1)) - 64'd1);
    lo = -hi - 64'sd1;
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/vector_alu_pipe_dot_chunk_mac.sv
// One VDOT chunk: DOT_P signed lane products summed into a single value.
module dot_chunk_mac
  import vector_alu_pkg::*;
#(
  parameter int LANE_W = 16,
  parameter int DOT_P  = 4
) (
  input  logic [DOT_P*LANE_W-1:0]                  a,
  input  logic [DOT_P*LANE_W-1:0]                  b,
  output logic signed [2*LANE_W+$clog2(DOT_P)-1:0] sum
);

  localparam int SW = 2*LANE_W + $clog2(DOT_P);

  logic signed [SW-1:0] pa;
  logic signed [SW-1:0] pb;

  // Sign-extend each lane pair to the sum width, multiply and accumulate.
  always_comb begin
    sum = '0;
    pa  = '0;
    pb  = '0;
    for (int j = 0; j < DOT_P; j++) begin
      pa  = SW'($signed(a[lane_lsb(j, LANE_W) +: LANE_W]));
      pb  = SW'($signed(b[lane_lsb(j, LANE_W) +: LANE_W]));
      sum = sum + pa * pb;
    end
  end

endmodule

// File: rtl/vector_alu_pipe.sv
// Registered vector ALU with valid/ready on both sides. VDOT accumulates
// DOT_P lanes per cycle; all other ops complete in one pass.
// Optional build macro VALU_SAT_EN: VADD, SMUL and the VDOT result narrowing
// saturate instead of wrapping (accumulator stays full width).
//
// state | meaning
// IDLE  | no result pending, ready for a request
// DOT   | VDOT accumulating chunk k, input stalled
// HOLD  | result presented, waiting for out_ready
module vector_alu_pipe
  import vector_alu_pkg::*;
#(
  parameter int LANES  = 16,
  parameter int LANE_W = 16,
  parameter int DOT_P  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [3:0]                in_opcode,
  input  logic [LANES*LANE_W-1:0]   in_op_1,
  input  logic [LANES*LANE_W-1:0]   in_op_2,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*LANE_W-1:0]   out_result,
  output logic                      out_illegal
);

  localparam int VW     = LANES * LANE_W;
  localparam int CHUNKS = LANES / DOT_P;
  localparam int KW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int SW     = 2*LANE_W + $clog2(DOT_P);
  localparam int AW     = 2*LANE_W + $clog2(LANES);

  state_e               state_q, state_d;
  logic [VW-1:0]        op1_q, op1_d;
  logic [VW-1:0]        op2_q, op2_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [KW-1:0]        k_q, k_d;
  logic [VW-1:0]        result_q, result_d;
  logic                 illegal_q, illegal_d;

  logic                 accept;
  logic [VW-1:0]        sp_res;
  logic                 sp_ill;
  logic [LANE_W-1:0]    a0, b0;
  logic signed [SW-1:0] mac_sum;
  logic signed [AW-1:0] mac_acc;

  function automatic logic [LANE_W-1:0] narrow(input logic signed [SAT_W-1:0] v);
`ifdef VALU_SAT_EN
    return LANE_W'(saturate(v, LANE_W));
`else
    return LANE_W'(v);
`endif
  endfunction

  assign in_ready    = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
  assign accept      = in_valid && in_ready;
  assign out_valid   = (state_q == HOLD);
  assign out_result  = result_q;
  assign out_illegal = illegal_q;

  dot_chunk_mac #(
    .LANE_W (LANE_W),
    .DOT_P  (DOT_P)
  ) u_mac (
    .a   (op1_q[int'(k_q)*DOT_P*LANE_W +: DOT_P*LANE_W]),
    .b   (op2_q[int'(k_q)*DOT_P*LANE_W +: DOT_P*LANE_W]),
    .sum (mac_sum)
  );

  assign mac_acc = acc_q + AW'(mac_sum);

  // Result of every op that completes in a single pass, from the live inputs.
  always_comb begin
    sp_res = '0;
    sp_ill = 1'b0;
    a0     = in_op_1[LANE_W-1:0];
    b0     = in_op_2[LANE_W-1:0];
    case (in_opcode)
      OP_VADD:
        for (int i = 0; i < LANES; i++)
          sp_res[lane_lsb(i, LANE_W) +: LANE_W] =
            narrow(SAT_W'($signed(in_op_1[lane_lsb(i, LANE_W) +: LANE_W])) +
                   SAT_W'($signed(in_op_2[lane_lsb(i, LANE_W) +: LANE_W])));
      OP_SMUL:
        for (int i = 0; i < LANES; i++)
          sp_res[lane_lsb(i, LANE_W) +: LANE_W] =
            narrow(SAT_W'($signed(a0)) *
                   SAT_W'($signed(in_op_2[lane_lsb(i, LANE_W) +: LANE_W])));
      OP_VLD, OP_VST: sp_res[LANE_W-1:0] = a0 + b0;
      OP_SLL:         sp_res[LANE_W-1:0] = {a0[LANE_W-1:8], b0[7:0]};
      OP_SLH:         sp_res[LANE_W-1:0] = {b0[7:0], a0[LANE_W-9:0]};
      OP_VDOT, OP_SST, OP_NOP: sp_res = '0;
      default:        sp_ill = 1'b1;
    endcase
  end

  // Next-state: DOT stepping, HOLD release, and request acceptance.
  always_comb begin
    state_d   = state_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    acc_d     = acc_q;
    k_d       = k_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    case (state_q)
      DOT: begin
        acc_d = mac_acc;
        k_d   = k_q + 1'b1;
        if (k_q == KW'(CHUNKS - 1)) begin
          state_d               = HOLD;
          k_d                   = '0;
          result_d              = '0;
          result_d[LANE_W-1:0]  = narrow(SAT_W'(mac_acc));
          illegal_d             = 1'b0;
        end
      end
      HOLD:    if (out_ready) state_d = IDLE;
      default: ;
    endcase
    // Acceptance only happens in IDLE or HOLD, so it never collides with DOT.
    if (accept) begin
      if (in_opcode == OP_VDOT) begin
        op1_d   = in_op_1;
        op2_d   = in_op_2;
        acc_d   = '0;
        k_d     = '0;
        state_d = DOT;
      end else begin
        result_d  = sp_res;
        illegal_d = sp_ill;
        state_d   = HOLD;
      end
    end
  end

  // State registers with synchronous reset; reset drops any pending result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op1_q     <= '0;
      op2_q     <= '0;
      acc_q     <= '0;
      k_q       <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      acc_q     <= acc_d;
      k_q       <= k_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_vector_alu_pipe.sv
// Self-checking bench for vector_alu_pipe: directed timing scenarios plus a
// randomized run scored against a lane-arithmetic reference model.
module tb_vector_alu_pipe;

  localparam int LANES = 16;
  localparam int LW    = 16;
  localparam int DOT_P = 4;
  localparam int VW    = LANES * LW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_opcode;
  logic [VW-1:0] in_op_1;
  logic [VW-1:0] in_op_2;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] out_result;
  logic          out_illegal;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [VW-1:0] res;
    logic          ill;
  } exp_t;
  exp_t exp_q[$];

  logic          hold_pend = 1'b0;
  logic [VW-1:0] held_res;
  logic          held_ill;

  vector_alu_pipe #(.LANES(LANES), .LANE_W(LW), .DOT_P(DOT_P)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_opcode   (in_opcode),
    .in_op_1     (in_op_1),
    .in_op_2     (in_op_2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [LW-1:0] nar(input longint v);
    logic [63:0] u;
`ifdef VALU_SAT_EN
    longint hi, lo;
    hi = (longint'(1) << (LW - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) v = hi;
    if (v < lo) v = lo;
`endif
    u = 64'(v);
    return u[LW-1:0];
  endfunction

  function automatic longint lane_s(input logic [VW-1:0] v, input int i);
    return longint'($signed(v[i*LW +: LW]));
  endfunction

  // Reference behaviour of one request, straight from the op definitions.
  function automatic exp_t model(input logic [3:0] op, input logic [VW-1:0] a,
                                 input logic [VW-1:0] b);
    exp_t   e;
    longint s;
    logic [LW-1:0] t;
    e.res = '0;
    e.ill = 1'b0;
    case (op)
      4'd0: for (int i = 0; i < LANES; i++) e.res[i*LW +: LW] = nar(lane_s(a, i) + lane_s(b, i));
      4'd1: begin
        s = 0;
        for (int i = 0; i < LANES; i++) s += lane_s(a, i) * lane_s(b, i);
        e.res[LW-1:0] = nar(s);
      end
      4'd2: for (int i = 0; i < LANES; i++) e.res[i*LW +: LW] = nar(lane_s(a, 0) * lane_s(b, i));
      4'd4, 4'd5: begin
        t = a[LW-1:0] + b[LW-1:0];
        e.res[LW-1:0] = t;
      end
      4'd6: e.res[LW-1:0] = {a[LW-1:8], b[7:0]};
      4'd7: e.res[LW-1:0] = {b[7:0], a[LW-9:0]};
      4'd3, 4'd15: ;
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [VW-1:0] rvec();
    logic [VW-1:0] r;
    for (int i = 0; i < VW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Scoreboard and hold-stability monitor, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
      hold_pend = 1'b0;
    end else begin
      if (hold_pend && out_valid) begin
        check("hold_stable_res", out_result, held_res);
        check("hold_stable_ill", VW'(out_illegal), VW'(held_ill));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("spurious_out", VW'(exp_q.size()), VW'(1));
        else begin
          e = exp_q.pop_front();
          check("sb_result", out_result, e.res);
          check("sb_illegal", VW'(out_illegal), VW'(e.ill));
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_opcode, in_op_1, in_op_2));
      hold_pend = out_valid && !out_ready;
      held_res  = out_result;
      held_ill  = out_illegal;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int w = 0; w < 20 && out_valid; w++) tick();
    check("go_idle", VW'(out_valid), VW'(0));
  endtask

  task automatic single(input string tag, input logic [3:0] op, input logic [VW-1:0] a,
                        input logic [VW-1:0] b, input logic [VW-1:0] er, input logic ei);
    go_idle();
    in_valid = 1'b1; in_opcode = op; in_op_1 = a; in_op_2 = b;
    tick();
    in_valid = 1'b0;
    check({tag, "_valid"}, VW'(out_valid), VW'(1));
    check({tag, "_res"}, out_result, er);
    check({tag, "_ill"}, VW'(out_illegal), VW'(ei));
  endtask

  task automatic vdot_23(input string tag);
    logic [VW-1:0] a, b;
    for (int i = 0; i < LANES; i++) begin
      a[i*LW +: LW] = 16'd2;
      b[i*LW +: LW] = 16'd3;
    end
    go_idle();
    in_valid = 1'b1; in_opcode = 4'd1; in_op_1 = a; in_op_2 = b;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= LANES/DOT_P; c++) begin
      check({tag, "_dot_valid"}, VW'(out_valid), VW'(0));
      check({tag, "_dot_ready"}, VW'(in_ready), VW'(0));
      tick();
    end
    check({tag, "_valid"}, VW'(out_valid), VW'(1));
    check({tag, "_res"}, out_result, VW'(16'h0060));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [VW-1:0] a, b, e;
    exp_t          se[4];
    logic          took, done;

    rst = 1'b1; in_valid = 1'b0; in_opcode = 4'd15; in_op_1 = '0; in_op_2 = '0;
    out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_out_valid", VW'(out_valid), VW'(0));
    check("rst_in_ready", VW'(in_ready), VW'(1));
    check("rst_result", out_result, '0);
    check("rst_illegal", VW'(out_illegal), VW'(0));

    // VADD wrap / saturate
    a = '0; b = '0; e = '0;
    a[15:0] = 16'h7FFF; b[15:0] = 16'h0001;
    a[63:48] = 16'h0005; b[63:48] = 16'hFFFE;
`ifdef VALU_SAT_EN
    e[15:0] = 16'h7FFF;
`else
    e[15:0] = 16'h8000;
`endif
    e[63:48] = 16'h0003;
    single("vadd", 4'd0, a, b, e, 1'b0);

    vdot_23("vdot");

    // SMUL with back-pressure
    go_idle();
    a = '0; a[15:0] = 16'h0003;
    for (int i = 0; i < LANES; i++) begin
      b[i*LW +: LW] = 16'h0010;
      e[i*LW +: LW] = 16'h0030;
    end
    out_ready = 1'b0;
    in_valid = 1'b1; in_opcode = 4'd2; in_op_1 = a; in_op_2 = b;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("smul_bp_valid", VW'(out_valid), VW'(1));
      check("smul_bp_res", out_result, e);
      check("smul_bp_ready", VW'(in_ready), VW'(0));
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("smul_release_ready", VW'(in_ready), VW'(1));
    check("smul_release_res", out_result, e);
    tick();
    check("smul_done_valid", VW'(out_valid), VW'(0));

    // Streaming VADDs, one per cycle
    go_idle();
    for (int i = 0; i < 4; i++) begin
      a = rvec(); b = rvec();
      se[i] = model(4'd0, a, b);
      in_valid = 1'b1; in_opcode = 4'd0; in_op_1 = a; in_op_2 = b;
      #1;
      check("stream_in_ready", VW'(in_ready), VW'(1));
      tick();
      check("stream_valid", VW'(out_valid), VW'(1));
      check("stream_res", out_result, se[i].res);
    end
    in_valid = 1'b0;

    // Lane-0 byte inserts and an undefined opcode
    a = '0; b = '0; a[15:0] = 16'hABCD; b[7:0] = 8'h12;
    single("sll", 4'd6, a, b, VW'(16'hAB12), 1'b0);
    single("slh", 4'd7, a, b, VW'(16'h12CD), 1'b0);
    single("illegal9", 4'd9, a, b, '0, 1'b1);

    // Reset during the second DOT cycle
    go_idle();
    in_valid = 1'b1; in_opcode = 4'd1; in_op_1 = rvec(); in_op_2 = rvec();
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstdot_out_valid", VW'(out_valid), VW'(0));
    check("rstdot_in_ready", VW'(in_ready), VW'(1));
    vdot_23("vdot_after_rst");

    // Randomized traffic with random back-pressure
    go_idle();
    for (int n = 0; n < 150; n++) begin
      in_opcode = ($urandom_range(0, 3) == 0) ? 4'd1 : 4'($urandom_range(0, 15));
      in_op_1 = rvec(); in_op_2 = rvec();
      in_valid = 1'b1;
      done = 1'b0;
      for (int w = 0; w < 64 && !done; w++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        took = in_ready;
        tick();
        if (took) done = 1'b1;
      end
      check("accept_timeout", VW'(done), VW'(1));
      in_valid = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        out_ready = $urandom_range(0, 1) != 0;
        tick();
      end
    end
    out_ready = 1'b1;
    for (int w = 0; w < 64 && (exp_q.size() != 0); w++) tick();
    check("drain_empty", VW'(exp_q.size()), VW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
